// File: rtl/cost_tbl_pkg.sv
// Shared types and sizes for the JAM cost-table responder.
// COST_TBL_ROWMIN_EN enables the row-minimum lower-bound accumulator.
package cost_tbl_pkg;

  localparam int N      = 8;
  localparam int COST_W = 7;
  localparam int LB_W   = 10;
  localparam int IDX_W  = 6;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N * N - 1);

  typedef enum logic {
    LOAD,
    FULL
  } state_t;

  function automatic logic [COST_W-1:0] min2(
    input logic [COST_W-1:0] a,
    input logic [COST_W-1:0] b
  );
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/cost_tbl_rsp_if.sv
// Load stream and W/J query port of the cost-table responder.
// Master is the search engine / loader, slave is the responder.
interface cost_tbl_rsp_if;
  import cost_tbl_pkg::*;

  logic              LD_VALID;
  logic              LD_READY;
  logic [COST_W-1:0] LD_DATA;
  logic              LD_LAST;
  logic              TBL_READY;
  logic [2:0]        W;
  logic [2:0]        J;
  logic [COST_W-1:0] Cost;

  modport master (
    output LD_VALID, LD_DATA, LD_LAST, W, J,
    input  LD_READY, TBL_READY, Cost
  );

  modport slave (
    input  LD_VALID, LD_DATA, LD_LAST, W, J,
    output LD_READY, TBL_READY, Cost
  );

endinterface

// File: rtl/cost_tbl_mem.sv
// 64-entry cost storage: one synchronous write, one async read.
// Storage is intentionally not reset.
module cost_tbl_mem
  import cost_tbl_pkg::*;
(
  input  logic              CLK,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [COST_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [COST_W-1:0] rdata
);

  logic [COST_W-1:0] mem [N*N];

  always_ff @(posedge CLK) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/cost_tbl_rsp.sv
// Cost-table responder: loads an 8x8 cost matrix, answers W/J queries.
// Optional COST_TBL_ROWMIN_EN: accumulates row minima into LB.
module cost_tbl_rsp
  import cost_tbl_pkg::*;
(
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            CLR,
  cost_tbl_rsp_if.slave   bus,
  output logic            ERR,
  output logic [LB_W-1:0] LB
);

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  k_q;
  logic              err_q;
  logic              ld_ready;
  logic              tbl_ready;
  logic              xfer;
  logic              last_k;
  logic [COST_W-1:0] rdata;

  assign ld_ready  = (state_q == LOAD);
  assign tbl_ready = (state_q == FULL);
  assign last_k    = (k_q == LAST_IDX);
  // CLR takes priority: a transfer in the clear cycle is dropped
  assign xfer      = bus.LD_VALID && ld_ready && !CLR;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= LOAD;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      CLR:             state_d = LOAD;
      (xfer && last_k): state_d = FULL;
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      k_q   <= '0;
      err_q <= 1'b0;
    end else if (CLR) begin
      k_q   <= '0;
      err_q <= 1'b0;
    end else if (xfer) begin
      k_q <= k_q + 1'b1;
      if (bus.LD_LAST != last_k) err_q <= 1'b1;
    end
  end

  cost_tbl_mem u_mem (
    .CLK   (CLK),
    .we    (xfer),
    .waddr (k_q),
    .wdata (bus.LD_DATA),
    .raddr ({bus.W, bus.J}),
    .rdata (rdata)
  );

  assign bus.LD_READY  = ld_ready;
  assign bus.TBL_READY = tbl_ready;
  assign bus.Cost      = tbl_ready ? rdata : '0;
  assign ERR           = err_q;

`ifdef COST_TBL_ROWMIN_EN
  logic [COST_W-1:0] min_q, min_d;
  logic [LB_W-1:0]   lb_q;

  // First entry of a row restarts the running minimum
  assign min_d = (k_q[2:0] == 3'd0) ? bus.LD_DATA
               : min2(bus.LD_DATA, min_q);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      min_q <= '0;
      lb_q  <= '0;
    end else if (CLR) begin
      min_q <= '0;
      lb_q  <= '0;
    end else if (xfer) begin
      min_q <= min_d;
      if (k_q[2:0] == 3'd7)
        lb_q <= lb_q + {{(LB_W-COST_W){1'b0}}, min_d};
    end
  end

  assign LB = lb_q;
`else
  assign LB = '0;
`endif

endmodule

// File: tb/tb_cost_tbl_rsp.sv
// Directed testbench for cost_tbl_rsp.
// Expected LB follows COST_TBL_ROWMIN_EN.
module tb_cost_tbl_rsp;

`ifdef COST_TBL_ROWMIN_EN
  localparam int LB_EXP = 224;
`else
  localparam int LB_EXP = 0;
`endif

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       CLR;
  logic       ERR;
  logic [9:0] LB;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  cost_tbl_rsp_if bus ();

  cost_tbl_rsp dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .CLR   (CLR),
    .bus   (bus),
    .ERR   (ERR),
    .LB    (LB)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_clr();
    CLR = 1'b1;
    step();
    CLR = 1'b0;
  endtask

  // Drives entries lo..hi-1; flags TBL_READY or non-zero Cost seen early
  task automatic load_table(
    input  bit rev,
    input  int lo,
    input  int hi,
    input  int stall_at,
    input  int bad_last,
    output bit early,
    output bit cost_nz
  );
    early   = 1'b0;
    cost_nz = 1'b0;
    bus.W   = 3'd3;
    bus.J   = 3'd5;
    for (int k = lo; k < hi; k++) begin
      if (k == stall_at) begin
        repeat (3) begin
          bus.LD_VALID = 1'b0;
          bus.LD_DATA  = 7'd127;
          step();
          if (bus.TBL_READY !== 1'b0) early = 1'b1;
          if (bus.Cost !== 7'd0) cost_nz = 1'b1;
        end
      end
      bus.LD_VALID = 1'b1;
      bus.LD_DATA  = 7'(rev ? (k / 8) * 8 + 7 - (k % 8) : k);
      bus.LD_LAST  = (k == 63) || (k == bad_last);
      #1;
      if (bus.TBL_READY !== 1'b0) early = 1'b1;
      if (bus.Cost !== 7'd0) cost_nz = 1'b1;
      step();
    end
    bus.LD_VALID = 1'b0;
    bus.LD_LAST  = 1'b0;
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    CLR = 1'b0;
    bus.LD_VALID = 1'b0;
    bus.LD_DATA = '0;
    bus.LD_LAST = 1'b0;
    bus.W = 3'd0;
    bus.J = 3'd0;
    step();
    step();
    checks++;
    if (bus.LD_READY !== 1'b1) begin
      errors++;
      $display("FAIL reset_ld_ready: got %b expected 1", bus.LD_READY);
    end
    checks++;
    if (bus.TBL_READY !== 1'b0) begin
      errors++;
      $display("FAIL reset_tbl_ready: got %b expected 0", bus.TBL_READY);
    end
    checks++;
    if (bus.Cost !== 7'd0) begin
      errors++;
      $display("FAIL reset_cost: got %0d expected 0", bus.Cost);
    end
    checks++;
    if (ERR !== 1'b0 || LB !== 10'd0) begin
      errors++;
      $display("FAIL reset_err_lb: got %b/%0d expected 0/0", ERR, LB);
    end
    RST_N = 1'b1;
    step();
  endtask

  task automatic test_basic();
    bit early, cnz;
    load_table(1'b0, 0, 64, -1, -1, early, cnz);
    checks++;
    if (early || cnz) begin
      errors++;
      $display("FAIL basic_during_load: got early=%b cost_nz=%b expected 0/0",
               early, cnz);
    end
    checks++;
    if (bus.TBL_READY !== 1'b1 || bus.LD_READY !== 1'b0) begin
      errors++;
      $display("FAIL basic_ready: got tbl=%b ld=%b expected 1/0",
               bus.TBL_READY, bus.LD_READY);
    end
    checks++;
    if (bus.Cost !== 7'd29) begin
      errors++;
      $display("FAIL basic_cost_3_5: got %0d expected 29", bus.Cost);
    end
    bus.W = 3'd6;
    bus.J = 3'd2;
    #1;
    checks++;
    if (bus.Cost !== 7'd50) begin
      errors++;
      $display("FAIL basic_cost_6_2: got %0d expected 50", bus.Cost);
    end
    checks++;
    if (ERR !== 1'b0) begin
      errors++;
      $display("FAIL basic_err: got %b expected 0", ERR);
    end
    checks++;
    if (LB !== 10'(LB_EXP)) begin
      errors++;
      $display("FAIL basic_lb: got %0d expected %0d", LB, LB_EXP);
    end
  endtask

  task automatic test_stall();
    bit early, cnz;
    do_clr();
    load_table(1'b0, 0, 64, 20, -1, early, cnz);
    checks++;
    if (early || cnz) begin
      errors++;
      $display("FAIL stall_during_load: got early=%b cost_nz=%b expected 0/0",
               early, cnz);
    end
    checks++;
    if (bus.TBL_READY !== 1'b1) begin
      errors++;
      $display("FAIL stall_tbl_ready: got %b expected 1", bus.TBL_READY);
    end
    bus.W = 3'd2;
    bus.J = 3'd4;
    #1;
    checks++;
    if (bus.Cost !== 7'd20) begin
      errors++;
      $display("FAIL stall_cost_2_4: got %0d expected 20", bus.Cost);
    end
    bus.J = 3'd5;
    #1;
    checks++;
    if (bus.Cost !== 7'd21) begin
      errors++;
      $display("FAIL stall_cost_2_5: got %0d expected 21", bus.Cost);
    end
  endtask

  task automatic test_err();
    bit early, cnz;
    do_clr();
    load_table(1'b0, 0, 11, -1, 10, early, cnz);
    checks++;
    if (ERR !== 1'b1) begin
      errors++;
      $display("FAIL err_set: got %b expected 1", ERR);
    end
    load_table(1'b0, 11, 64, -1, -1, early, cnz);
    checks++;
    if (bus.TBL_READY !== 1'b1 || ERR !== 1'b1) begin
      errors++;
      $display("FAIL err_complete: got tbl=%b err=%b expected 1/1",
               bus.TBL_READY, ERR);
    end
    do_clr();
    checks++;
    if (ERR !== 1'b0 || bus.LD_READY !== 1'b1 || bus.TBL_READY !== 1'b0) begin
      errors++;
      $display("FAIL err_clr: got err=%b ld=%b tbl=%b expected 0/1/0",
               ERR, bus.LD_READY, bus.TBL_READY);
    end
    checks++;
    if (LB !== 10'd0) begin
      errors++;
      $display("FAIL err_clr_lb: got %0d expected 0", LB);
    end
  endtask

  task automatic test_clr_priority();
    bit early, cnz;
    load_table(1'b0, 0, 5, -1, -1, early, cnz);
    CLR = 1'b1;
    bus.LD_VALID = 1'b1;
    bus.LD_DATA = 7'd127;
    step();
    CLR = 1'b0;
    bus.LD_VALID = 1'b0;
    load_table(1'b0, 0, 64, -1, -1, early, cnz);
    checks++;
    if (early || bus.TBL_READY !== 1'b1) begin
      errors++;
      $display("FAIL clr_prio_count: got early=%b tbl=%b expected 0/1",
               early, bus.TBL_READY);
    end
    bus.W = 3'd0;
    bus.J = 3'd0;
    #1;
    checks++;
    if (bus.Cost !== 7'd0) begin
      errors++;
      $display("FAIL clr_prio_entry0: got %0d expected 0", bus.Cost);
    end
  endtask

  task automatic test_full_ignore();
    bus.W = 3'd0;
    bus.J = 3'd0;
    bus.LD_VALID = 1'b1;
    bus.LD_DATA = 7'd127;
    repeat (5) begin
      step();
      checks++;
      if (bus.LD_READY !== 1'b0 || bus.Cost !== 7'd0) begin
        errors++;
        $display("FAIL full_ignore: got ld=%b cost=%0d expected 0/0",
                 bus.LD_READY, bus.Cost);
      end
    end
    bus.LD_VALID = 1'b0;
    bus.W = 3'd7;
    bus.J = 3'd7;
    #1;
    checks++;
    if (bus.Cost !== 7'd63) begin
      errors++;
      $display("FAIL full_cost_7_7: got %0d expected 63", bus.Cost);
    end
  endtask

  task automatic test_reset_midload();
    bit early, cnz;
    do_clr();
    load_table(1'b0, 0, 30, -1, 5, early, cnz);
    RST_N = 1'b0;
    #1;
    checks++;
    if (bus.LD_READY !== 1'b1 || bus.TBL_READY !== 1'b0 ||
        bus.Cost !== 7'd0 || ERR !== 1'b0 || LB !== 10'd0) begin
      errors++;
      $display("FAIL midload_reset: got ld=%b tbl=%b cost=%0d err=%b lb=%0d expected 1/0/0/0/0",
               bus.LD_READY, bus.TBL_READY, bus.Cost, ERR, LB);
    end
    step();
    RST_N = 1'b1;
    step();
    load_table(1'b0, 0, 64, -1, -1, early, cnz);
    checks++;
    if (early || bus.TBL_READY !== 1'b1) begin
      errors++;
      $display("FAIL midload_reload: got early=%b tbl=%b expected 0/1",
               early, bus.TBL_READY);
    end
    bus.W = 3'd7;
    bus.J = 3'd7;
    #1;
    checks++;
    if (bus.Cost !== 7'd63) begin
      errors++;
      $display("FAIL midload_cost_7_7: got %0d expected 63", bus.Cost);
    end
  endtask

  task automatic test_reversed();
    bit early, cnz;
    do_clr();
    load_table(1'b1, 0, 64, -1, -1, early, cnz);
    checks++;
    if (LB !== 10'(LB_EXP)) begin
      errors++;
      $display("FAIL rev_lb: got %0d expected %0d", LB, LB_EXP);
    end
    bus.W = 3'd0;
    bus.J = 3'd0;
    #1;
    checks++;
    if (bus.Cost !== 7'd7) begin
      errors++;
      $display("FAIL rev_cost_0_0: got %0d expected 7", bus.Cost);
    end
    bus.W = 3'd5;
    bus.J = 3'd7;
    #1;
    checks++;
    if (bus.Cost !== 7'd40) begin
      errors++;
      $display("FAIL rev_cost_5_7: got %0d expected 40", bus.Cost);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_err();
    test_clr_priority();
    test_full_ignore();
    test_reset_midload();
    test_reversed();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
